// File: rtl/wave_scheduler.sv
// wave_scheduler: sequences enemy waves (one-at-a-time spawn ramp, alive mask, kill count).
// Latency: every output is registered; inputs sampled on an edge are visible right after it.
// Backpressure: none; frame_tick/start/plane_hit are one-cycle pulses consumed on arrival.
// Ports: clk, reset (synchronous, active-high), frame_tick, start, plane_hit[9:0], player_dead in;
//        plane_amount[3:0] (drives amount_control), alive[9:0], wave[3:0], kills[7:0], game_over out.
module wave_scheduler #(
   parameter int SPAWN_GAP    = 30,
   parameter int CLEAR_FRAMES = 60,
   parameter int MAX_WAVE     = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic [9:0] plane_hit,
   input  logic       player_dead,
   output logic [3:0] plane_amount,
   output logic [9:0] alive,
   output logic [3:0] wave,
   output logic [7:0] kills,
   output logic       game_over
);

   // One counter serves both the spawn gap and the clear pause, so size it for the larger.
   localparam int CNT_MAX = (SPAWN_GAP > CLEAR_FRAMES) ? SPAWN_GAP : CLEAR_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SPAWN_GAP_C    = CNT_W'(SPAWN_GAP);
   localparam logic [CNT_W-1:0] CLEAR_FRAMES_C = CNT_W'(CLEAR_FRAMES);
   localparam logic [3:0]       MAX_WAVE_C     = 4'(MAX_WAVE);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SPAWN = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_CLEAR = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]       amount_d, amount_inc, wave_d;
   logic [9:0]       alive_d, hit_vld, spawn_bit;
   logic [7:0]       kills_d;
   logic [8:0]       kills_sum;
   logic             over_d;

   function automatic logic [3:0] popcount10(input logic [9:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 10; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

   always_comb begin
      // Hits are masked with the alive bits from before this edge, so a plane
      // spawned in the same cycle cannot be hit yet.
      hit_vld   = ((state_q == ST_SPAWN) || (state_q == ST_PLAY)) ? (plane_hit & alive) : '0;
      kills_sum = {1'b0, kills} + {5'b00000, popcount10(hit_vld)};
      cnt_inc    = cnt_q + 1'b1;
      amount_inc = plane_amount + 4'd1;
      spawn_bit  = 10'd1 << plane_amount;

      state_d  = state_q;
      cnt_d    = cnt_q;
      amount_d = plane_amount;
      wave_d   = wave;
      over_d   = game_over;
      alive_d  = alive & ~hit_vld;
      kills_d  = kills_sum[8] ? 8'hFF : kills_sum[7:0];

      if ((state_q == ST_IDLE) || (state_q == ST_OVER)) begin
         if (start) begin
            state_d  = ST_SPAWN;
            wave_d   = 4'd1;
            kills_d  = '0;
            amount_d = '0;
            alive_d  = '0;
            cnt_d    = '0;
            over_d   = 1'b0;
         end
      end else if (player_dead) begin
         // Death wins over spawn and every other transition; hits above still count.
         state_d = ST_OVER;
         over_d  = 1'b1;
      end else if (state_q == ST_SPAWN) begin
         if (frame_tick) begin
            if (cnt_inc == SPAWN_GAP_C) begin
               cnt_d    = '0;
               alive_d  = alive_d | spawn_bit;
               amount_d = amount_inc;
               if (amount_inc == wave) begin
                  state_d = ST_PLAY;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
      end else if (state_q == ST_PLAY) begin
         // Registered alive is tested, giving one cycle between the last kill and CLEAR.
         if (alive == '0) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      end else if (state_q == ST_CLEAR) begin
         if (frame_tick) begin
            if (cnt_inc == CLEAR_FRAMES_C) begin
               state_d  = ST_SPAWN;
               wave_d   = (wave >= MAX_WAVE_C) ? MAX_WAVE_C : (wave + 4'd1);
               amount_d = '0;
               alive_d  = '0;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
      end else begin
         // Unreachable encodings recover to IDLE.
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         plane_amount <= '0;
         alive        <= '0;
         wave         <= '0;
         kills        <= '0;
         game_over    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         plane_amount <= amount_d;
         alive        <= alive_d;
         wave         <= wave_d;
         kills        <= kills_d;
         game_over    <= over_d;
      end
   end

endmodule
